// File: rtl/i2c_master_seq.sv
`timescale 1ns/1ps
// i2c_master_seq: command-driven I2C master that sequences a complete
// single-byte register write, or a random read with repeated START,
// toward an EEPROM-style slave. SCL is push-pull; SDA is open-drain.
module i2c_master_seq #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [7:0]  DEV_ID  = 8'hA0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_rw_i,
  input  logic [7:0] cmd_addr_i,
  input  logic [7:0] cmd_wdata_i,
  output logic [7:0] rd_data_o,
  output logic       done_o,
  output logic       ack_err_o,
  output logic       busy_o,
  output logic       i2c_scl_o,
  inout  wire        i2c_sda_io
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_TX_BYTE, S_RX_ACK, S_RSTART,
    S_RX_BYTE, S_TX_NACK, S_STOP, S_DONE
  } state_e;

  localparam logic [7:0] QMAX  = 8'(CLK_DIV - 1);
  localparam logic [7:0] RD_ID = DEV_ID | 8'h01;

  state_e     state_q, state_d;
  logic [7:0] qcnt_q, qcnt_d;    // clk count within a quarter bit
  logic [1:0] ph_q, ph_d;        // quarter phase within a bit period
  logic [2:0] bit_q, bit_d;      // bit index, MSB first
  logic [1:0] byte_q, byte_d;    // byte index within the transaction
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic       rw_q, rw_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rd_q, rd_d;
  logic       err_q, err_d;
  logic [1:0] sync_q;
  logic       bit_end;
  logic       scl;
  logic       sda_oe;

  // Last clk of ph3: the bus sample point and the bit-period boundary.
  assign bit_end = (qcnt_q == QMAX) && (ph_q == 2'd3);

  // Two-flop synchroniser for the SDA input; idles high like the bus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst_i) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], i2c_sda_io};
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      ph_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: bit timer plus transaction sequencing on bit_end.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_d = state_q;
    qcnt_d  = qcnt_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    err_d   = err_q;

    if (state_q != S_IDLE && state_q != S_DONE) begin
      if (qcnt_q == QMAX) begin
        qcnt_d = '0;
        ph_d   = ph_q + 2'd1;
      end else begin
        qcnt_d = qcnt_q + 8'd1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        qcnt_d = '0;
        ph_d   = '0;
        if (cmd_valid_i) begin
          state_d = S_START;
          rw_d    = cmd_rw_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          tx_d    = DEV_ID;
          byte_d  = 2'd0;
          bit_d   = 3'd7;
          err_d   = 1'b0;
        end
      end
      S_START: if (bit_end) begin
        state_d = S_TX_BYTE;
        bit_d   = 3'd7;
      end
      S_TX_BYTE: if (bit_end) begin
        if (bit_q == 3'd0) begin
          state_d = S_RX_ACK;
        end else begin
          bit_d = bit_q - 3'd1;
          tx_d  = {tx_q[6:0], 1'b0};
        end
      end
      S_RX_ACK: if (bit_end) begin
        bit_d = 3'd7;
        if (sync_q[1]) begin
          // NACK: abandon the remaining bytes and release the bus.
          err_d   = 1'b1;
          state_d = S_STOP;
        end else begin
          case (byte_q)
            2'd0: begin
              tx_d    = addr_q;
              byte_d  = 2'd1;
              state_d = S_TX_BYTE;
            end
            2'd1: begin
              byte_d = 2'd2;
              if (rw_q) begin
                state_d = S_RSTART;
              end else begin
                tx_d    = wdata_q;
                state_d = S_TX_BYTE;
              end
            end
            default: begin
              if (rw_q) begin
                byte_d  = 2'd3;
                state_d = S_RX_BYTE;
              end else begin
                state_d = S_STOP;
              end
            end
          endcase
        end
      end
      S_RSTART: if (bit_end) begin
        tx_d    = RD_ID;
        bit_d   = 3'd7;
        state_d = S_TX_BYTE;
      end
      S_RX_BYTE: if (bit_end) begin
        rx_d = {rx_q[6:0], sync_q[1]};
        if (bit_q == 3'd0) state_d = S_TX_NACK;
        else               bit_d   = bit_q - 3'd1;
      end
      S_TX_NACK: if (bit_end) begin
        rd_d    = rx_q;
        state_d = S_STOP;
      end
      S_STOP: if (bit_end) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus waveform decode from state and quarter phase.
  always_comb begin
    scl    = 1'b1;
    sda_oe = 1'b0;
    unique case (state_q)
      S_START:   begin scl = (ph_q != 2'd3);                  sda_oe = ph_q[1];  end
      S_RSTART:  begin scl = (ph_q == 2'd1) || (ph_q == 2'd2); sda_oe = ph_q[1];  end
      S_STOP:    begin scl = (ph_q != 2'd0);                  sda_oe = !ph_q[1]; end
      S_TX_BYTE: begin scl = ph_q[1];                         sda_oe = !tx_q[7]; end
      S_RX_ACK, S_RX_BYTE, S_TX_NACK: scl = ph_q[1];
      default: ;
    endcase
  end

  assign i2c_scl_o   = scl;
  assign i2c_sda_io  = sda_oe ? 1'b0 : 1'bz;
  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign ack_err_o   = err_q;
  assign rd_data_o   = rd_q;

endmodule

// File: tb/tb_i2c_master_seq.sv
`timescale 1ns/1ps
// Directed bench for i2c_master_seq: two instances (CLK_DIV 4 and 3) share
// one behavioural EEPROM slave and bus monitor, selected by sel.
module tb_i2c_master_seq;

  logic       clk;
  logic       rst;
  logic       cmd_valid, cmd_rw;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       sel;      // 0: CLK_DIV=4 instance, 1: CLK_DIV=3 instance
  logic       slv_en;   // slave present on the bus
  int         cyc;
  int         n_run, n_fail;

  logic       ready4, done4, err4, busy4, scl4;
  logic [7:0] rdata4;
  logic       ready3, done3, err3, busy3, scl3;
  logic [7:0] rdata3;
  wire        sda4, sda3;
  logic       cmd_valid4, cmd_valid3;

  // Slave model and monitor state
  logic       s_act, s_tx, s_pend, s_drv;
  int         s_cnt, s_byte;
  logic [7:0] s_sh, s_txsh, s_ptr;
  logic [7:0] s_mem [0:255];
  logic [8:0] mon_q [$];   // {ack bit, data byte}
  int         mon_starts, mon_stops;

  pullup (sda4);
  pullup (sda3);
  assign sda4 = (slv_en && s_drv && !sel) ? 1'b0 : 1'bz;
  assign sda3 = (slv_en && s_drv &&  sel) ? 1'b0 : 1'bz;
  assign cmd_valid4 = cmd_valid && !sel;
  assign cmd_valid3 = cmd_valid &&  sel;

  i2c_master_seq #(.CLK_DIV(4), .DEV_ID(8'hA0)) dut4 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid4), .cmd_ready_o(ready4),
    .cmd_rw_i(cmd_rw), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rd_data_o(rdata4), .done_o(done4), .ack_err_o(err4), .busy_o(busy4),
    .i2c_scl_o(scl4), .i2c_sda_io(sda4));

  i2c_master_seq #(.CLK_DIV(3), .DEV_ID(8'hA0)) dut3 (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid3), .cmd_ready_o(ready3),
    .cmd_rw_i(cmd_rw), .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
    .rd_data_o(rdata3), .done_o(done3), .ack_err_o(err3), .busy_o(busy3),
    .i2c_scl_o(scl3), .i2c_sda_io(sda3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Bus monitor and EEPROM slave, sampled on the falling clk edge.
  initial begin
    logic p_scl, p_sda, c_scl, c_sda;
    int   bitc;
    logic [7:0] msh;
    p_scl = 1'b1; p_sda = 1'b1; bitc = 0; msh = '0;
    s_act = 1'b0; s_tx = 1'b0; s_pend = 1'b0; s_drv = 1'b0;
    s_cnt = 0; s_byte = 0; s_sh = '0; s_txsh = '0; s_ptr = '0;
    mon_starts = 0; mon_stops = 0;
    forever begin
      @(negedge clk);
      c_scl = sel ? scl3 : scl4;
      c_sda = sel ? sda3 : sda4;
      if (p_scl && c_scl && p_sda && !c_sda) begin
        mon_starts++;
        bitc = 0;
        s_act = 1'b1; s_tx = 1'b0; s_pend = 1'b0; s_drv = 1'b0;
        s_cnt = 0; s_byte = 0;
      end else if (p_scl && c_scl && !p_sda && c_sda) begin
        mon_stops++;
        bitc = 0;
        s_act = 1'b0; s_tx = 1'b0; s_drv = 1'b0;
      end else begin
        if (!p_scl && c_scl) begin
          if (bitc < 8) begin
            msh  = {msh[6:0], c_sda};
            bitc++;
          end else begin
            mon_q.push_back({c_sda, msh});
            bitc = 0;
          end
          if (s_act) begin
            if (!s_tx && s_cnt < 8) s_sh = {s_sh[6:0], c_sda};
            s_cnt++;
          end
        end
        if (p_scl && !c_scl && s_act) begin
          if (s_cnt == 8 && !s_tx) begin
            case (s_byte)
              0: begin
                if (s_sh[7:1] == 7'h50) begin
                  s_drv  = 1'b1;
                  s_pend = s_sh[0];
                end else begin
                  s_act = 1'b0;
                end
              end
              1: begin
                s_ptr = s_sh;
                s_drv = 1'b1;
              end
              default: begin
                s_mem[s_ptr] = s_sh;
                s_ptr++;
                s_drv = 1'b1;
              end
            endcase
          end else if (s_cnt == 9) begin
            s_cnt = 0;
            s_byte++;
            s_drv = 1'b0;
            s_tx  = 1'b0;
            if (s_pend) begin
              s_pend = 1'b0;
              s_tx   = 1'b1;
              s_txsh = s_mem[s_ptr];
              s_drv  = !s_txsh[7];
            end
          end else if (s_tx && s_cnt < 8) begin
            s_drv = !s_txsh[7 - s_cnt];
          end else if (s_tx && s_cnt == 8) begin
            s_drv = 1'b0;
          end
        end
      end
      p_scl = c_scl;
      p_sda = c_sda;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] mon_at(input int i);
    if (i >= 0 && i < mon_q.size()) return mon_q[i];
    return 9'bx;
  endfunction

  // Present one command for one cycle; t0 is the accepting cycle.
  task automatic issue(input logic rw, input logic [7:0] a, input logic [7:0] d, output int t0);
    @(posedge clk); #1;
    cmd_rw = rw; cmd_addr = a; cmd_wdata = d; cmd_valid = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Wait for done_o of the selected instance; dc = -1 on timeout.
  task automatic wait_done(input int budget, output int dc);
    dc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sel ? done3 : done4) begin
        dc = cyc;
        break;
      end
    end
  endtask

  initial begin
    int t0, t1, dc, b, st0, sp0;
    n_run = 0; n_fail = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    sel = 1'b0; slv_en = 1'b1;

    // Reset values, with a command presented while reset is held
    repeat (2) @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_addr = 8'hEE; cmd_wdata = 8'h11;
    @(posedge clk); #1;
    check("rst_ready", ready4, 1);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_ack_err", err4, 0);
    check("rst_rd_data", rdata4, 8'h00);
    check("rst_scl", scl4, 1);
    check("rst_sda", sda4, 1);
    cmd_valid = 1'b0; rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("rst_no_capture", busy4, 0);

    // Write 0x5A to 0x12
    b = mon_q.size(); st0 = mon_starts; sp0 = mon_stops;
    issue(1'b0, 8'h12, 8'h5A, t0);
    check("wr_busy", busy4, 1);
    check("wr_ready_low", ready4, 0);
    wait_done(600, dc);
    check("wr_done_lat", dc - t0, 465);
    check("wr_done_busy", busy4, 0);
    check("wr_ack_err", err4, 0);
    check("wr_bytes", {mon_at(b), mon_at(b+1), mon_at(b+2)}, {9'h0A0, 9'h012, 9'h05A});
    check("wr_nbytes", mon_q.size() - b, 3);
    check("wr_starts", mon_starts - st0, 1);
    check("wr_stops", mon_stops - sp0, 1);
    check("wr_mem", s_mem[8'h12], 8'h5A);
    @(negedge clk);
    check("wr_ready_after", ready4, 1);

    // Random read of 0x12
    b = mon_q.size(); st0 = mon_starts; sp0 = mon_stops;
    issue(1'b1, 8'h12, 8'h00, t0);
    wait_done(800, dc);
    check("rd_done_lat", dc - t0, 625);
    check("rd_data", rdata4, 8'h5A);
    check("rd_ack_err", err4, 0);
    check("rd_bytes", {mon_at(b), mon_at(b+1), mon_at(b+2), mon_at(b+3)},
          {9'h0A0, 9'h012, 9'h0A1, 9'h15A});
    check("rd_starts", mon_starts - st0, 2);
    check("rd_stops", mon_stops - sp0, 1);

    // No slave: NACK on the device-ID byte
    slv_en = 1'b0;
    b = mon_q.size(); sp0 = mon_stops;
    issue(1'b0, 8'h34, 8'h77, t0);
    wait_done(300, dc);
    check("nack_done_lat", dc - t0, 177);
    check("nack_ack_err", err4, 1);
    check("nack_rd_data", rdata4, 8'h5A);
    check("nack_byte", mon_at(b), 9'h1A0);
    check("nack_nbytes", mon_q.size() - b, 1);
    check("nack_stops", mon_stops - sp0, 1);
    slv_en = 1'b1;

    // Command pulse while busy is ignored; a held command follows done
    b = mon_q.size();
    issue(1'b0, 8'h20, 8'hC3, t0);
    check("hold_err_cleared", err4, 0);
    repeat (100) @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_rw = 1'b1; cmd_addr = 8'h99;
    check("pulse_ready_low", ready4, 0);
    @(posedge clk); #1 cmd_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1 cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 8'h21; cmd_wdata = 8'h3C;
    wait_done(600, dc);
    check("hold_first_lat", dc - t0, 465);
    @(posedge clk); #1;
    check("hold_ready_idle", ready4, 1);
    check("hold_busy_idle", busy4, 0);
    @(posedge clk); #1;
    check("hold_busy_start", busy4, 1);
    cmd_valid = 1'b0;
    t1 = dc + 1;
    wait_done(600, dc);
    check("hold_second_lat", dc - t1, 465);
    check("hold_bytes", {mon_at(b), mon_at(b+1), mon_at(b+2), mon_at(b+3), mon_at(b+4), mon_at(b+5)},
          {9'h0A0, 9'h020, 9'h0C3, 9'h0A0, 9'h021, 9'h03C});
    check("hold_mem20", s_mem[8'h20], 8'hC3);
    check("hold_mem21", s_mem[8'h21], 8'h3C);

    // Reset asserted during the read data byte
    issue(1'b1, 8'h20, 8'h00, t0);
    repeat (500) @(posedge clk);
    #1;
    check("mid_busy_before", busy4, 1);
    slv_en = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_rst_scl", scl4, 1);
    check("mid_rst_sda", sda4, 1);
    check("mid_rst_busy", busy4, 0);
    check("mid_rst_ready", ready4, 1);
    check("mid_rst_rd_data", rdata4, 8'h00);
    @(posedge clk); #1 rst = 1'b0; slv_en = 1'b1;
    b = mon_q.size();
    issue(1'b0, 8'h40, 8'hE7, t0);
    wait_done(600, dc);
    check("post_rst_lat", dc - t0, 465);
    check("post_rst_ack_err", err4, 0);
    check("post_rst_bytes", {mon_at(b), mon_at(b+1), mon_at(b+2)}, {9'h0A0, 9'h040, 9'h0E7});
    check("post_rst_mem", s_mem[8'h40], 8'hE7);

    // CLK_DIV=3 instance write
    @(posedge clk); #1 sel = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("div3_ready", ready3, 1);
    b = mon_q.size(); st0 = mon_starts; sp0 = mon_stops;
    issue(1'b0, 8'h55, 8'hAA, t0);
    wait_done(500, dc);
    check("div3_lat", dc - t0, 349);
    check("div3_ack_err", err3, 0);
    check("div3_bytes", {mon_at(b), mon_at(b+1), mon_at(b+2)}, {9'h0A0, 9'h055, 9'h0AA});
    check("div3_starts", mon_starts - st0, 1);
    check("div3_stops", mon_stops - sp0, 1);
    check("div3_mem", s_mem[8'h55], 8'hAA);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
